muldiv_sequencer: RTL and testbench

//  Iterative RV32M multiply/divide unit with its own sequencing FSM, beside the main ALU in EX.

---
 rtl/muldiv_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with sequencing FSM
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_op;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic                   r_neg;
  logic [CW-1:0]          r_count;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_result;

  // Operand decode in IDLE: signedness, magnitudes and special cases
  logic                   w_is_div;
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_sign_a;
  logic                   w_sign_b;
  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic                   w_div_zero;
  logic                   w_ovf;
  logic                   w_special;
  logic [WIDTH-1:0]       w_special_res;
  logic                   w_neg;

  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                      (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_sign_a   = w_a_signed & rs1[WIDTH-1];
  assign w_sign_b   = w_b_signed & rs2[WIDTH-1];
  assign w_abs_a    = w_sign_a ? -rs1 : rs1;
  assign w_abs_b    = w_sign_b ? -rs2 : rs2;
  assign w_div_zero = w_is_div & (rs2 == '0);
  assign w_ovf      = w_is_div & ~funct3[0] &
                      (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2 == '1);
  assign w_special  = w_div_zero | w_ovf;
  // Remainder follows the dividend sign; product and quotient follow sign mismatch
  assign w_neg      = (w_is_div & funct3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);

  // Special-case results: funct3[1] selects the remainder flavour
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = funct3[1] ? rs1 : '1;
    end else begin
      w_special_res = funct3[1] ? '0 : rs1;
    end
  end

  // One radix-2 iteration: shift-add multiply and restoring divide step
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_mul_next;
  logic [WIDTH:0]         w_shift_rem;
  logic [WIDTH-1:0]       w_trial;
  logic                   w_fits;
  logic [2*WIDTH-1:0]     w_div_next;

  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : '0)};
  assign w_mul_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_shift_rem = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial     = w_shift_rem[WIDTH-1:0] - r_b;
  assign w_fits      = (w_shift_rem >= {1'b0, r_b});
  assign w_div_next  = w_fits ? {w_trial, r_acc[WIDTH-2:0], 1'b1}
                              : {w_shift_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign fix-up and result selection
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [WIDTH-1:0]       w_fix_res;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Select the requested half of the product, quotient or remainder
  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and status outputs; flush overrides every transition
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          stall        = 1'b1;
          w_next_state = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        stall = 1'b1;
        if (r_count == '0) begin
          w_next_state = S_FIX;
        end
      end
      S_FIX: begin
        stall        = 1'b1;
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (flush) begin
      w_next_state = S_IDLE;
    end
  end

  // Datapath: latch operands, iterate, and register the final result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= funct3;
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_neg   <= w_neg;
            r_count <= CW'(WIDTH - 1);
            r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end
        S_CALC: begin
          r_acc   <= r_op[2] ? w_div_next : w_mul_next;
          r_count <= r_count - CW'(1);
        end
        S_FIX: begin
          r_result <= w_fix_res;
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [2:0]   funct3;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [7:0]  lat;
  } vec_t;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics from wide arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic signed [31:0] as32, bs32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    as32 = a;
    bs32 = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return as32 / bs32;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return as32 % bs32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return W + 2;
  endfunction

  // Pulse start for one cycle, scramble operands afterwards, wait for done (bounded)
  task automatic issue_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls, output logic [31:0] res);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    stalls = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 100) begin
      if (stall) stalls++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = result;
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL %s done pulses got %0d want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({stall, busy, done} !== 3'b000 || result !== '0) begin
      n_err++;
      $display("FAIL reset_state got s%b b%b d%b r%h want zeros", stall, busy, done, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tbl[14];
    int lat, stalls;
    logic [31:0] res;
    tbl = '{
      '{3'd0, 32'd7,         32'd6,         32'd42,        8'd34},
      '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         8'd34},
      '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  8'd34},
      '{3'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  8'd34},
      '{3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  8'd34},
      '{3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  8'd34},
      '{3'd5, 32'd100,       32'd7,         32'd14,        8'd34},
      '{3'd7, 32'd100,       32'd7,         32'd2,         8'd34},
      '{3'd4, 32'd5,         32'd0,         32'hFFFFFFFF,  8'd1},
      '{3'd7, 32'd5,         32'd0,         32'd5,         8'd1},
      '{3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  8'd1},
      '{3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,         8'd1},
      '{3'd5, 32'd5,         32'd0,         32'hFFFFFFFF,  8'd1},
      '{3'd6, 32'd5,         32'd0,         32'd5,         8'd1}
    };
    foreach (tbl[i]) begin
      issue_op(tbl[i].f, tbl[i].a, tbl[i].b, lat, stalls, res);
      n_vec++;
      if (res !== tbl[i].r) begin
        n_err++;
        $display("FAIL directed[%0d] result got %h want %h", i, res, tbl[i].r);
      end
      n_vec++;
      if (lat !== int'(tbl[i].lat)) begin
        n_err++;
        $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, tbl[i].lat);
      end
      n_vec++;
      if (stalls !== int'(tbl[i].lat)) begin
        n_err++;
        $display("FAIL directed[%0d] stall cycles got %0d want %0d", i, stalls, tbl[i].lat);
      end
    end
  endtask

  task automatic test_random();
    int lat, stalls;
    logic [31:0] res, a, b;
    logic [2:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
        3: b = {{28{b[31]}}, b[3:0]};
        default: ;
      endcase
      issue_op(f, a, b, lat, stalls, res);
      n_vec++;
      if (res !== ref_result(f, a, b) || lat !== ref_latency(f, a, b)) begin
        n_err++;
        $display("FAIL random[%0d] f=%0d a=%h b=%h got %h/lat %0d want %h/lat %0d",
                 i, f, a, b, res, lat, ref_result(f, a, b), ref_latency(f, a, b));
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL random[%0d] after done got d%b b%b want d0 b0", i, done, busy);
      end
    end
  endtask

  task automatic test_flush();
    int lat, stalls;
    logic [31:0] r0;
    issue_op(3'd3, 32'h12345678, 32'h9ABCDEF0, lat, stalls, r0);
    n_vec++;
    if (r0 !== ref_result(3'd3, 32'h12345678, 32'h9ABCDEF0)) begin
      n_err++;
      $display("FAIL flush_prior result got %h want %h", r0,
               ref_result(3'd3, 32'h12345678, 32'h9ABCDEF0));
    end
    @(negedge clk);
    funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== r0) begin
      n_err++;
      $display("FAIL flush_idle got b%b d%b s%b r%h want b0 d0 s0 r%h",
               busy, done, stall, result, r0);
    end
    watch_no_done("flush_no_done", 40);
    n_vec++;
    if (result !== r0) begin
      n_err++;
      $display("FAIL flush_result_held got %h want %h", result, r0);
    end
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_beats_start stall got %b want 0", stall);
    end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_beats_start busy got %b want 0", busy);
    end
    issue_op(3'd5, 32'd100, 32'd7, lat, stalls, r0);
    n_vec++;
    if (r0 !== 32'd14 || lat !== W + 2) begin
      n_err++;
      $display("FAIL flush_recover got %h/lat %0d want %h/lat %0d", r0, lat, 32'd14, W + 2);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (!done && lat < 100) begin
      rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    n_vec++;
    if (result !== 32'd14 || lat !== W + 2) begin
      n_err++;
      $display("FAIL held_start op got %h/lat %0d want %h/lat %0d", result, lat, 32'd14, W + 2);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_done got b%b d%b want b0 d0", busy, done);
    end
    start = 1'b0;
    watch_no_done("start_in_done_no_done", 40);
  endtask

  task automatic test_reset_mid();
    int lat, stalls;
    logic [31:0] res;
    issue_op(3'd0, 32'd7, 32'd6, lat, stalls, res);
    n_vec++;
    if (res !== 32'd42) begin
      n_err++;
      $display("FAIL reset_mid_prior got %h want %h", res, 32'd42);
    end
    @(negedge clk);
    funct3 = 3'd3; rs1 = $urandom; rs2 = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_vec++;
    if ({stall, busy, done} !== 3'b000 || result !== '0) begin
      n_err++;
      $display("FAIL reset_mid got s%b b%b d%b r%h want zeros", stall, busy, done, result);
    end
    @(negedge clk);
    reset = 1'b0;
    watch_no_done("reset_mid_no_done", 40);
    issue_op(3'd6, 32'hFFFFFFF9, 32'd2, lat, stalls, res);
    n_vec++;
    if (res !== 32'hFFFFFFFF || lat !== W + 2) begin
      n_err++;
      $display("FAIL reset_mid_recover got %h/lat %0d want %h/lat %0d",
               res, lat, 32'hFFFFFFFF, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_start_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
